// File: rtl/panda_posgen_pkg.sv
// Shared definitions for the PandA position generator: state encoding,
// register defaults and the per-point position update.
package panda_posgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] START_DEFAULT  = 32'd0;
  localparam logic [31:0] STEP_DEFAULT   = 32'd1;
  localparam logic [31:0] PERIOD_DEFAULT = 32'd1;
  localparam logic [31:0] NUM_DEFAULT    = 32'd0;
  localparam logic        DIR_DEFAULT    = 1'b0;

  // Modulo-2^32 step in either direction; wrap-around is intentional.
  function automatic logic [31:0] next_posn(input logic [31:0] posn,
                                            input logic [31:0] step,
                                            input logic        dir);
    return dir ? (posn - step) : (posn + step);
  endfunction

endpackage

// File: rtl/panda_posgen_tick.sv
// PERIOD prescaler: after a load, tick_o fires every period_i enabled clocks,
// the first one period_i clocks after the load.
module panda_posgen_tick
  import panda_posgen_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [31:0] period_i,
  output logic        tick_o
);

  logic [31:0] period_q;
  logic [31:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      period_q <= PERIOD_DEFAULT;
      cnt_q    <= 32'd0;
    end else if (clear_i) begin
      cnt_q <= 32'd0;
    end else if (load_i) begin
      period_q <= period_i;
      cnt_q    <= period_i - 32'd1;
    end else if (en_i) begin
      cnt_q <= (cnt_q == 32'd0) ? (period_q - 32'd1) : (cnt_q - 32'd1);
    end
  end

  assign tick_o = en_i && (cnt_q == 32'd0);

endmodule

// File: rtl/panda_posgen.sv
// Position generator: on a rising enable emits NUM points (or forever) from
// START in STEP increments, one every PERIOD clocks, with strobe/active/error flags.
module panda_posgen
  import panda_posgen_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [31:0] START,
  input  logic [31:0] STEP,
  input  logic [31:0] PERIOD,
  input  logic [31:0] NUM,
  input  logic        DIR,
  output logic [31:0] posn_o,
  output logic        strobe_o,
  output logic        act_o,
  output logic        err_o
);

  state_t      state_q;
  logic        en_q;
  logic        arm_q;
  logic [31:0] step_q;
  logic [31:0] num_q;
  logic        dir_q;
  logic [31:0] count_q;
  logic [31:0] posn_q;
  logic        strobe_q;
  logic        act_q;
  logic        err_q;

  logic rise;
  logic start_ok;
  logic tick;
  logic last_done;
  logic tick_load;
  logic tick_clear;
  logic tick_en;

  // arm_q blocks a start until enable has been seen low since reset, so an
  // enable held high through reset release does not count as an edge.
  assign rise       = enable_i && !en_q && arm_q;
  assign start_ok   = rise && (state_q != RUN) && (PERIOD != 32'd0);
  assign last_done  = (num_q != 32'd0) && (count_q == num_q);
  assign tick_en    = (state_q == RUN);
  assign tick_load  = start_ok;
  assign tick_clear = (state_q == RUN) && (!enable_i || (tick && last_done));

  panda_posgen_tick u_tick (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (tick_load),
    .clear_i  (tick_clear),
    .en_i     (tick_en),
    .period_i (PERIOD),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      arm_q    <= 1'b0;
      step_q   <= STEP_DEFAULT;
      num_q    <= NUM_DEFAULT;
      dir_q    <= DIR_DEFAULT;
      count_q  <= 32'd0;
      posn_q   <= START_DEFAULT;
      strobe_q <= 1'b0;
      act_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      en_q     <= enable_i;
      arm_q    <= arm_q | ~enable_i;
      strobe_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (rise) begin
            step_q <= STEP;
            num_q  <= NUM;
            dir_q  <= DIR;
            if (PERIOD == 32'd0) begin
              err_q   <= 1'b1;
              act_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              posn_q   <= START;
              strobe_q <= 1'b1;
              act_q    <= 1'b1;
              err_q    <= 1'b0;
              count_q  <= 32'd1;
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          if (!enable_i) begin
            act_q   <= 1'b0;
            count_q <= 32'd0;
            state_q <= IDLE;
          end else if (tick) begin
            if (last_done) begin
              act_q   <= 1'b0;
              count_q <= 32'd0;
              state_q <= DONE;
            end else begin
              posn_q   <= next_posn(posn_q, step_q, dir_q);
              strobe_q <= 1'b1;
              count_q  <= count_q + 32'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign posn_o   = posn_q;
  assign strobe_o = strobe_q;
  assign act_o    = act_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_panda_posgen.sv
// Directed bench for panda_posgen: a timeline model predicts every output each
// cycle, and per-scenario literal point lists pin the model.
module tb_panda_posgen;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [31:0] START, STEP, PERIOD, NUM;
  logic        DIR;
  logic [31:0] posn_o;
  logic        strobe_o, act_o, err_o;

  int checks = 0;
  int failures = 0;

  panda_posgen dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .enable_i (enable_i),
    .START    (START),
    .STEP     (STEP),
    .PERIOD   (PERIOD),
    .NUM      (NUM),
    .DIR      (DIR),
    .posn_o   (posn_o),
    .strobe_o (strobe_o),
    .act_o    (act_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Model: a sequence started at edge t0 emits point k at edge t0 + k*P with
  // position START +/- k*STEP, and stays active until edge t0 + N*P.
  longint      cyc = 0;
  bit          m_valid = 0;
  bit          m_hist, m_armed, m_run;
  longint      m_t0;
  logic [31:0] m_start, m_step, m_per, m_num;
  logic        m_dir;
  logic [31:0] e_posn;
  logic        e_strobe, e_act, e_err;

  function automatic logic [31:0] posn_at(input longint k);
    logic [31:0] ofs;
    ofs = m_step * 32'(k);
    return m_dir ? (m_start - ofs) : (m_start + ofs);
  endfunction

  always @(posedge clk) begin
    longint d;
    cyc++;
    if (reset_i) begin
      m_valid = 1; m_hist = 0; m_armed = 0; m_run = 0;
      e_posn = 0; e_strobe = 0; e_act = 0; e_err = 0;
    end else if (m_valid) begin
      e_strobe = 0;
      if (m_run) begin
        d = cyc - m_t0;
        if (!enable_i) begin
          m_run = 0; e_act = 0;
        end else if (m_num != 0 && d >= longint'(m_num) * longint'(m_per)) begin
          m_run = 0; e_act = 0;
        end else if (d % longint'(m_per) == 0) begin
          e_strobe = 1;
          e_posn = posn_at(d / longint'(m_per));
        end
      end else if (enable_i && !m_hist && m_armed) begin
        m_start = START; m_step = STEP; m_per = PERIOD; m_num = NUM; m_dir = DIR;
        if (PERIOD == 0) begin
          e_err = 1; e_act = 0;
        end else begin
          m_run = 1; m_t0 = cyc;
          e_posn = START; e_strobe = 1; e_act = 1; e_err = 0;
        end
      end
      m_armed = m_armed | !enable_i;
      m_hist = enable_i;
    end
  end

  // Strobe log and act fall time, used by the literal per-scenario checks.
  logic [31:0] log_posn[$];
  longint      log_cyc[$];
  longint      fall_cyc;
  bit          prev_act = 0;
  logic [31:0] exp_pts[$];

  always @(negedge clk) begin
    if (m_valid) begin
      chk("posn_o", posn_o, e_posn);
      chk("strobe_o", {31'b0, strobe_o}, {31'b0, e_strobe});
      chk("act_o", {31'b0, act_o}, {31'b0, e_act});
      chk("err_o", {31'b0, err_o}, {31'b0, e_err});
      if (strobe_o === 1'b1) begin
        log_posn.push_back(posn_o);
        log_cyc.push_back(cyc);
      end
      if (prev_act && act_o === 1'b0) fall_cyc = cyc;
      prev_act = (act_o === 1'b1);
    end
  end

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_log();
    log_posn.delete();
    log_cyc.delete();
    exp_pts.delete();
    fall_cyc = -1;
  endtask

  task automatic set_regs(input logic [31:0] s, input logic [31:0] st,
                          input logic [31:0] p, input logic [31:0] n, input logic d);
    START = s; STEP = st; PERIOD = p; NUM = n; DIR = d;
  endtask

  // Compares the strobe log with exp_pts, their spacing, and (tail >= 0) the
  // delay from the last strobe to act_o falling.
  task automatic check_run(input string nm, input int gap, input int tail);
    chk({nm, " count"}, 32'(log_posn.size()), 32'(exp_pts.size()));
    for (int i = 0; i < exp_pts.size() && i < log_posn.size(); i++) begin
      chk($sformatf("%s pt%0d", nm, i), log_posn[i], exp_pts[i]);
      if (i > 0) chk($sformatf("%s gap%0d", nm, i), 32'(log_cyc[i] - log_cyc[i-1]), 32'(gap));
    end
    if (tail >= 0 && log_cyc.size() > 0)
      chk({nm, " tail"}, 32'(fall_cyc - log_cyc[log_cyc.size()-1]), 32'(tail));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1; enable_i = 0;
    set_regs(32'd0, 32'd1, 32'd1, 32'd0, 1'b0);
    step_clk(3);
    chk("reset posn", posn_o, 32'd0);
    chk("reset act", {31'b0, act_o}, 32'd0);
    reset_i = 0;
    step_clk(2);

    // Basic run
    set_regs(32'd100, 32'd10, 32'd4, 32'd3, 1'b0);
    clear_log();
    exp_pts = '{32'd100, 32'd110, 32'd120};
    enable_i = 1;
    step_clk(20);
    check_run("basic", 4, 4);
    enable_i = 0;
    step_clk(2);

    // Decrementing wrap, back-to-back strobes
    set_regs(32'd5, 32'd3, 32'd1, 32'd3, 1'b1);
    clear_log();
    exp_pts = '{32'd5, 32'h0000_0002, 32'hFFFF_FFFF};
    enable_i = 1;
    step_clk(8);
    check_run("wrap", 1, 1);
    enable_i = 0;
    step_clk(2);

    // Illegal period, then recovery
    set_regs(32'd7, 32'd1, 32'd0, 32'd2, 1'b0);
    clear_log();
    enable_i = 1;
    step_clk(4);
    chk("illegal err", {31'b0, err_o}, 32'd1);
    chk("illegal act", {31'b0, act_o}, 32'd0);
    check_run("illegal", 1, -1);
    enable_i = 0;
    step_clk(2);
    PERIOD = 32'd2;
    enable_i = 1;
    step_clk(2);
    chk("recover err", {31'b0, err_o}, 32'd0);
    chk("recover act", {31'b0, act_o}, 32'd1);
    step_clk(8);
    exp_pts = '{32'd7, 32'd8};
    check_run("recover", 2, 2);
    enable_i = 0;
    step_clk(2);

    // Abort after the 5th strobe of an unlimited run
    set_regs(32'd1000, 32'd25, 32'd2, 32'd0, 1'b0);
    clear_log();
    enable_i = 1;
    for (int i = 0; i < 100 && log_posn.size() < 5; i++) step_clk(1);
    enable_i = 0;
    step_clk(6);
    exp_pts = '{32'd1000, 32'd1025, 32'd1050, 32'd1075, 32'd1100};
    check_run("abort", 2, -1);
    chk("abort posn", posn_o, 32'd1100);
    chk("abort act", {31'b0, act_o}, 32'd0);

    // Reset mid-run with enable held high
    set_regs(32'd50, 32'd5, 32'd3, 32'd0, 1'b0);
    enable_i = 1;
    step_clk(7);
    reset_i = 1;
    step_clk(1);
    chk("midreset posn", posn_o, 32'd0);
    chk("midreset act", {31'b0, act_o}, 32'd0);
    clear_log();
    reset_i = 0;
    step_clk(5);
    check_run("no restart", 1, -1);
    chk("no restart act", {31'b0, act_o}, 32'd0);
    enable_i = 0;
    step_clk(2);
    enable_i = 1;
    step_clk(2);
    chk("restart act", {31'b0, act_o}, 32'd1);
    chk("restart posn", posn_o, 32'd50);
    enable_i = 0;
    step_clk(2);

    // Register changes during RUN are ignored
    set_regs(32'd0, 32'd7, 32'd2, 32'd4, 1'b0);
    clear_log();
    exp_pts = '{32'd0, 32'd7, 32'd14, 32'd21};
    enable_i = 1;
    step_clk(3);
    STEP = 32'd100; START = 32'd999;
    step_clk(12);
    check_run("isolation", 2, 2);
    enable_i = 0;
    step_clk(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
